// File: rtl/image_line_feeder_pkg.sv
// image_line_feeder_pkg: shared state encoding, defaults and counter width helper
package image_line_feeder_pkg;
  typedef enum logic [2:0] {IDLE, SEND, WAIT, DRAIN, DONE} state_t;
  localparam int DEFAULT_WIDTH = 512;
  localparam int DEFAULT_PREFILL = 4;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/image_rd_pipe.sv
// image_rd_pipe: two-stage valid/data pipeline aligning frame memory reads to pixel output
module image_rd_pipe (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rd,
  input  logic [7:0] i_data,
  output logic [7:0] o_data,
  output logic       o_valid
);
  logic r_rd;
  // stage 1 tracks the issued read, stage 2 registers the returned memory byte
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_rd    <= 1'b0;
      o_valid <= 1'b0;
      o_data  <= '0;
    end else begin
      r_rd    <= i_rd;
      o_valid <= r_rd;
      if (r_rd) o_data <= i_data;
    end
endmodule

// File: rtl/image_line_feeder.sv
// image_line_feeder: streams a frame line by line into the window generator under line credits
module image_line_feeder
  import image_line_feeder_pkg::*;
#(
  parameter int IMG_WIDTH     = DEFAULT_WIDTH,
  parameter int IMG_HEIGHT    = 512,
  parameter int ADDR_W        = 18,
  parameter int PREFILL_LINES = DEFAULT_PREFILL
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_intr,
  output logic              o_mem_rd,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [7:0]        i_mem_data,
  output logic [7:0]        o_pixel_data,
  output logic              o_pixel_data_valid,
  output logic              o_busy,
  output logic              o_done
);
  localparam int PW = cnt_w(IMG_WIDTH);
  localparam int LW = cnt_w(IMG_HEIGHT + 1);
  state_t r_state, w_next;
  logic [PW-1:0] r_pix;
  logic [LW-1:0] r_lines, r_intrs, w_lines_next, w_intrs_next;
  logic [2:0] r_credits, w_credits_next;
  logic [3:0] w_credit_sum;
  logic [ADDR_W-1:0] r_addr;
  logic w_line_end, w_intr;
  assign w_line_end     = (r_state == SEND) && (r_pix == PW'(IMG_WIDTH - 1));
  assign w_intr         = i_intr && (r_state != IDLE);
  assign w_credit_sum   = 4'(r_credits) + 4'(w_intr) - 4'(w_line_end);
  assign w_credits_next = (w_credit_sum > 4'(PREFILL_LINES)) ? 3'(PREFILL_LINES) : w_credit_sum[2:0];
  assign w_lines_next   = r_lines + LW'(w_line_end);
  assign w_intrs_next   = r_intrs + LW'(w_intr);
  assign o_mem_rd       = (r_state == SEND);
  assign o_mem_addr     = r_addr;
  assign o_busy         = (r_state == SEND) || (r_state == WAIT) || (r_state == DRAIN);
  assign o_done         = (r_state == DONE);
  // state register
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_state <= IDLE;
    else r_state <= w_next;
  // next state: credits and interrupts seen this cycle count immediately
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = i_start ? SEND : IDLE;
      SEND:    if (w_line_end) w_next = (w_lines_next == LW'(IMG_HEIGHT)) ? DRAIN : (w_credits_next != 3'd0) ? SEND : WAIT;
      WAIT:    w_next = (w_credits_next != 3'd0) ? SEND : WAIT;
      DRAIN:   w_next = (w_intrs_next >= LW'(IMG_HEIGHT - 2)) ? DONE : DRAIN;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // address, pixel, line, interrupt and credit counters
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_addr    <= '0;
      r_pix     <= '0;
      r_lines   <= '0;
      r_intrs   <= '0;
      r_credits <= '0;
    end else if (r_state == IDLE) begin
      if (i_start) begin
        r_addr    <= '0;
        r_pix     <= '0;
        r_lines   <= '0;
        r_intrs   <= '0;
        r_credits <= 3'(PREFILL_LINES);
      end
    end else begin
      r_credits <= w_credits_next;
      r_lines   <= w_lines_next;
      r_intrs   <= w_intrs_next;
      if (r_state == SEND) begin
        r_addr <= r_addr + 1'b1;
        r_pix  <= w_line_end ? '0 : r_pix + 1'b1;
      end
    end
  image_rd_pipe u_pipe (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_rd   (o_mem_rd),
    .i_data (i_mem_data),
    .o_data (o_pixel_data),
    .o_valid(o_pixel_data_valid)
  );
endmodule
